// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented when no instruction is buffered.
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  // Sequential next-PC; wraps naturally at the top of the address space.
  function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO for fetch results. Flush empties it in one cycle and
// takes priority over push/pop. DEPTH must be a power of two, at least 2.
module if_fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and occupancy; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array needs no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // The credit scheme upstream must never push into a full FIFO without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency word reads to
// instruction memory, buffers results and hands them to decode with a
// valid/ready handshake. A redirect flushes buffered and in-flight fetches.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirect targets raise a
// sticky misalign_err and halt fetch until an aligned redirect or reset.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misalign_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PKT_W = $bits(fetch_pkt_t);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;

  logic             halt;
  logic [XLEN-1:0]  redirect_target;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  fetch_pkt_t       push_pkt;
  fetch_pkt_t       head_pkt;
  logic [PKT_W-1:0] head_bits;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Misaligned redirect target arms the sticky error; an aligned one clears it.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) begin
      misalign_d = |redirect_pc[1:0];
    end
  end

  // Error/halt flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign halt            = misalign_q;
  assign misalign_err    = misalign_q;
  assign redirect_target = redirect_pc;
`else
  assign halt            = 1'b0;
  assign misalign_err    = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

  // Buffer slots already spoken for: current entries minus the one leaving this
  // cycle plus the response still on its way back from memory.
  assign occupancy = {1'b0, fifo_count}
                   - {{CNT_W{1'b0}}, fifo_pop}
                   + {{CNT_W{1'b0}}, inflight_q};

  assign out_valid = !reset && !redirect_valid && (fifo_count != '0);
  assign fifo_pop  = out_valid && out_ready;

  assign imem_req  = !reset && !redirect_valid && !halt
                   && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  // A response lands in the FIFO unless a redirect (now or last cycle) voids it.
  assign fifo_push      = inflight_q && !drop_q && !redirect_valid;
  assign push_pkt.pc    = req_pc_q;
  assign push_pkt.instr = imem_rdata;

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_pkt),
    .pop       (fifo_pop),
    .head_data (head_bits),
    .count     (fifo_count)
  );

  assign head_pkt  = head_bits;
  assign out_pc    = head_pkt.pc;
  assign out_instr = (fifo_count != '0) ? head_pkt.instr : NOP_INSTR;

  // PC sequencing: redirect has priority, otherwise advance on each issued request.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    drop_d     = 1'b0;
    if (redirect_valid) begin
      pc_d   = redirect_target;
      drop_d = inflight_q;
    end else if (imem_req) begin
      req_pc_d = pc_q;
      pc_d     = pc_next_seq(pc_q);
    end
  end

  // Fetch control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule
